// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with trap/branch/return redirects and a return-address stack.
// Latency: a redirect or advance requested in cycle N appears on fetch_pc in cycle N+1.
// Backpressure: fetch_pc holds while fetch_valid & !fetch_ready (or stall) unless a redirect squashes the request.
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              STEP       = 4,
    parameter logic [XLEN-1:0] ALIGN_MASK = 3,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] pc_plus_step,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            br_req,
    input  logic [XLEN-1:0] br_target,
    input  logic            call_push,
    input  logic [XLEN-1:0] push_addr,
    input  logic            ret_pop,
    output logic            ras_empty,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    localparam int              PW     = $clog2(RAS_DEPTH);
    localparam int              CW     = PW + 1;
    localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state;

    // Return-address stack: circular buffer, top points at the newest entry.
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_top;
    logic [CW-1:0]   ras_cnt;

    logic            ras_full;
    logic            in_run;
    logic            pop_ok;
    logic            push_ok;
    logic            flush;
    logic            redir_vld;
    logic [XLEN-1:0] redir_tgt;
    logic            tgt_bad;
    logic [XLEN-1:0] trap_tgt;
    logic            adv;

    assign pc_plus_step = fetch_pc + STEP_V;
    assign ras_empty    = (ras_cnt == '0);
    assign ras_full     = (ras_cnt == CW'(RAS_DEPTH));
    assign in_run       = (state == S_RUN);

    // A trap always wins, so it suppresses any same-cycle RAS activity; a branch blocks the pop only.
    assign pop_ok    = in_run & ret_pop & ~ras_empty & ~br_req & ~trap_req;
    assign push_ok   = in_run & call_push & ~trap_req;
    assign flush     = trap_req & (state != S_BOOT);

    assign redir_vld = br_req | pop_ok;
    assign redir_tgt = br_req ? br_target : ras_mem[ras_top];
    assign tgt_bad   = |(redir_tgt & ALIGN_MASK);
    assign trap_tgt  = trap_vec & ~ALIGN_MASK;
    assign adv       = fetch_valid & fetch_ready & ~stall;

    // Sequencer: boot, run with prioritised next-PC selection, halt on misaligned target until a trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_BOOT;
            fetch_pc      <= RESET_PC;
            fetch_valid   <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            case (state)
                S_BOOT: begin
                    state       <= S_RUN;
                    fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (trap_req) begin
                        fetch_pc <= trap_tgt;
                    end else if (redir_vld) begin
                        if (tgt_bad) begin
                            state         <= S_HALT;
                            fetch_valid   <= 1'b0;
                            misalign      <= 1'b1;
                            misalign_addr <= redir_tgt;
                        end else begin
                            fetch_pc <= redir_tgt;
                        end
                    end else if (adv) begin
                        fetch_pc <= pc_plus_step;
                    end
                end
                S_HALT: begin
                    if (trap_req) begin
                        state       <= S_RUN;
                        fetch_valid <= 1'b1;
                        fetch_pc    <= trap_tgt;
                        misalign    <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    // RAS pointer and occupancy; a simultaneous push and pop replaces the top in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_top <= '0;
            ras_cnt <= '0;
        end else if (flush) begin
            ras_cnt <= '0;
        end else if (pop_ok && push_ok) begin
            ras_cnt <= ras_cnt;
        end else if (pop_ok) begin
            ras_top <= ras_top - PW'(1);
            ras_cnt <= ras_cnt - CW'(1);
        end else if (push_ok) begin
            ras_top <= ras_top + PW'(1);
            if (!ras_full) begin
                ras_cnt <= ras_cnt + CW'(1);
            end
        end
    end

    // RAS storage; a push when full lands on the oldest slot, silently dropping it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            ras_mem[pop_ok ? ras_top : ras_top + PW'(1)] <= push_addr;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] pc_plus_step;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic        br_req;
    logic [31:0] br_target;
    logic        call_push;
    logic [31:0] push_addr;
    logic        ret_pop;
    logic        ras_empty;
    logic        misalign;
    logic [31:0] misalign_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN(32), .RESET_PC(32'h100), .STEP(4), .ALIGN_MASK(32'h3), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .pc_plus_step(pc_plus_step),
        .trap_req(trap_req), .trap_vec(trap_vec), .br_req(br_req), .br_target(br_target),
        .call_push(call_push), .push_addr(push_addr), .ret_pop(ret_pop),
        .ras_empty(ras_empty), .misalign(misalign), .misalign_addr(misalign_addr)
    );

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] pcs;
        logic        mis;
        logic [31:0] maddr;
        logic        empty;
    } exp_t;

    exp_t expq[$];

    // Reference model: mode 0 = booting, 1 = running, 2 = halted; RAS as a plain list, newest last.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_maddr;
    logic [31:0] m_ras[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h100;
        m_mis   = 1'b0;
        m_maddr = 32'h0;
        m_ras.delete();
    endtask

    task automatic model_edge();
        logic        have_t;
        logic        popped;
        logic [31:0] t;
        have_t = 1'b0;
        popped = 1'b0;
        t      = 32'h0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (trap_req) begin
                m_mode = 1;
                m_pc   = {trap_vec[31:2], 2'b00};
                m_mis  = 1'b0;
                m_ras.delete();
            end
        end else if (trap_req) begin
            m_pc = {trap_vec[31:2], 2'b00};
            m_ras.delete();
        end else begin
            if (br_req) begin
                have_t = 1'b1;
                t      = br_target;
            end else if (ret_pop && m_ras.size() > 0) begin
                have_t = 1'b1;
                t      = m_ras[m_ras.size()-1];
                popped = 1'b1;
            end
            if (popped && call_push) begin
                m_ras[m_ras.size()-1] = push_addr;
            end else if (popped) begin
                void'(m_ras.pop_back());
            end else if (call_push) begin
                m_ras.push_back(push_addr);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            if (have_t) begin
                if (t[1:0] != 2'b00) begin
                    m_mode  = 2;
                    m_mis   = 1'b1;
                    m_maddr = t;
                end else begin
                    m_pc = t;
                end
            end else if (fetch_ready && !stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: model consumes the inputs seen at the edge and queues the expected outputs.
    task automatic step(input int n = 1);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            e.vld   = (m_mode == 1);
            e.pc    = m_pc;
            e.pcs   = m_pc + 32'd4;
            e.mis   = m_mis;
            e.maddr = m_maddr;
            e.empty = (m_ras.size() == 0);
            expq.push_back(e);
            #1;
        end
    endtask

    task automatic clr();
        stall       = 1'b0;
        fetch_ready = 1'b1;
        trap_req    = 1'b0;
        trap_vec    = 32'h0;
        br_req      = 1'b0;
        br_target   = 32'h0;
        call_push   = 1'b0;
        push_addr   = 32'h0;
        ret_pop     = 1'b0;
    endtask

    // Mid-run reset: outputs must change before any clock edge arrives.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_pc", fetch_pc, 32'h100);
        chk("rst_empty", {31'h0, ras_empty}, 32'h1);
        chk("rst_mis", {31'h0, misalign}, 32'h0);
        model_reset();
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare every presented output set against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && expq.size() > 0) begin
            e = expq.pop_front();
            chk("mon_valid", {31'h0, fetch_valid}, {31'h0, e.vld});
            chk("mon_pc", fetch_pc, e.pc);
            chk("mon_pcs", pc_plus_step, e.pcs);
            chk("mon_mis", {31'h0, misalign}, {31'h0, e.mis});
            chk("mon_maddr", misalign_addr, e.maddr);
            chk("mon_empty", {31'h0, ras_empty}, {31'h0, e.empty});
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        model_reset();
        #3;
        do_reset();

        // Boot sequence then sequential fetch
        step(3);
        chk("boot_seq", fetch_pc, 32'h108);

        // Reset mid-run, then handshake hold and stall
        do_reset();
        step(2);
        fetch_ready = 1'b0;
        step(3);
        chk("hold_nordy", fetch_pc, 32'h104);
        fetch_ready = 1'b1;
        stall       = 1'b1;
        step(2);
        chk("hold_stall", fetch_pc, 32'h104);
        stall = 1'b0;

        // Wrap-around
        trap_req = 1'b1;
        trap_vec = 32'hFFFF_FFFC;
        step();
        trap_req = 1'b0;
        step();
        chk("wrap", fetch_pc, 32'h0);

        // Priority: trap beats branch and return, and flushes the RAS
        call_push = 1'b1;
        push_addr = 32'h44;
        step();
        call_push = 1'b0;
        trap_req  = 1'b1;
        trap_vec  = 32'h203;
        br_req    = 1'b1;
        br_target = 32'h400;
        ret_pop   = 1'b1;
        step();
        chk("prio_trap", fetch_pc, 32'h200);
        chk("prio_empty", {31'h0, ras_empty}, 32'h1);
        clr();

        // Branch beats return, RAS untouched
        call_push = 1'b1;
        push_addr = 32'h88;
        step();
        call_push = 1'b0;
        br_req    = 1'b1;
        br_target = 32'h400;
        ret_pop   = 1'b1;
        step();
        chk("prio_br", fetch_pc, 32'h400);
        chk("prio_br_ras", {31'h0, ras_empty}, 32'h0);
        br_req = 1'b0;
        step();
        chk("ret_after_br", fetch_pc, 32'h88);
        clr();

        // Overflow: five pushes into four entries, then five pops
        call_push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_addr = 32'h10 * i;
            step();
        end
        call_push = 1'b0;
        ret_pop   = 1'b1;
        step();
        chk("pop1", fetch_pc, 32'h50);
        step(3);
        chk("pop4", fetch_pc, 32'h20);
        step();
        chk("pop5_adv", fetch_pc, 32'h24);
        clr();

        // Simultaneous push and pop
        call_push = 1'b1;
        push_addr = 32'h30;
        step();
        push_addr = 32'h60;
        ret_pop   = 1'b1;
        step();
        chk("pushpop_tgt", fetch_pc, 32'h30);
        call_push = 1'b0;
        step();
        chk("pushpop_top", fetch_pc, 32'h60);
        clr();

        // Misaligned branch, halt, recover via trap
        br_req    = 1'b1;
        br_target = 32'h102;
        step();
        chk("mis_flag", {31'h0, misalign}, 32'h1);
        chk("mis_addr", misalign_addr, 32'h102);
        chk("mis_valid", {31'h0, fetch_valid}, 32'h0);
        br_target = 32'h400;
        step();
        chk("halt_ign", {31'h0, misalign}, 32'h1);
        br_req   = 1'b0;
        trap_req = 1'b1;
        trap_vec = 32'h80;
        step();
        chk("recover_pc", fetch_pc, 32'h80);
        chk("recover_mis", {31'h0, misalign}, 32'h0);
        clr();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 5) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            trap_req    = ($urandom_range(0, 29) == 0);
            trap_vec    = $urandom;
            br_req      = ($urandom_range(0, 7) == 0);
            br_target   = $urandom & ((($urandom_range(0, 9) == 0)) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            call_push   = ($urandom_range(0, 4) == 0);
            push_addr   = $urandom & ((($urandom_range(0, 9) == 0)) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            ret_pop     = ($urandom_range(0, 4) == 0);
            step();
        end
        clr();
        step(2);

        @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
